// File: rtl/crt_scale_seq.sv
// crt_scale_seq: multiplies one 30-bit residue by each of NUM_CONST
// constants read from an attached crt_rom, one product per 3 cycles.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      residue handshake, in_data = residue x
//   rom_addr/rom_data      constant index k out, combinational constant in
//   out_valid/out_ready    product handshake
//   out_data               x*c_k, full 60 bits
//   out_idx, out_last      k of the product, high when k = NUM_CONST-1
//   blk_cnt                completed-block counter (CRT_SCALE_SEQ_CNT_EN only)
//
// Optional macro: CRT_SCALE_SEQ_CNT_EN adds the saturating blk_cnt output.

module crt_scale_seq #(
    parameter int modular_index = 5,
    parameter int NUM_CONST     = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [29:0] in_data,
    output logic [2:0]  rom_addr,
    input  logic [29:0] rom_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [59:0] out_data,
    output logic [2:0]  out_idx,
`ifdef CRT_SCALE_SEQ_CNT_EN
    output logic [15:0] blk_cnt,
`endif
    output logic        out_last
);

    // modular_index only tags which ROM is attached; it has no effect
    // on the datapath beyond this sanity check.
    if (NUM_CONST < 1 || NUM_CONST > 8 || modular_index < 0) begin : g_bad_cfg
        $error("crt_scale_seq: NUM_CONST must be 1..8");
    end

    localparam logic [2:0] K_LAST = 3'(NUM_CONST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        MUL  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  k_q;
    logic [2:0]  k_d;
    logic [29:0] x_q;
    logic [29:0] c_q;
    logic [59:0] out_data_q;
    logic [2:0]  out_idx_q;
    logic        out_last_q;

    // Only used when the current product is not the last one, so k
    // can never step beyond K_LAST or wrap inside a block.
    assign k_d = k_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= 3'd0;
            x_q        <= 30'd0;
            c_q        <= 30'd0;
            out_data_q <= 60'd0;
            out_idx_q  <= 3'd0;
            out_last_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= in_data;
                        k_q     <= 3'd0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    c_q     <= rom_data;
                    state_q <= MUL;
                end
                MUL: begin
                    out_data_q <= 60'(x_q) * 60'(c_q);
                    out_idx_q  <= k_q;
                    out_last_q <= (k_q == K_LAST);
                    state_q    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q <= IDLE;
                        end else begin
                            k_q     <= k_d;
                            state_q <= READ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign rom_addr  = k_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

`ifdef CRT_SCALE_SEQ_CNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= 16'd0;
        end else if (out_valid && out_ready && out_last_q
                     && blk_cnt_q != 16'hFFFF) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_crt_scale_seq.sv
// tb_crt_scale_seq: directed, table-driven bench for crt_scale_seq
// with a behavioural crt_rom (modular_index 5) attached.

module tb_crt_scale_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_data = 30'd0;
    logic [2:0]  rom_addr;
    logic [29:0] rom_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [59:0] out_data;
    logic [2:0]  out_idx;
    logic        out_last;
`ifdef CRT_SCALE_SEQ_CNT_EN
    logic [15:0] blk_cnt;
`endif

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    crt_scale_seq #(
        .modular_index(5),
        .NUM_CONST(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_idx(out_idx),
`ifdef CRT_SCALE_SEQ_CNT_EN
        .blk_cnt(blk_cnt),
`endif
        .out_last(out_last)
    );

    function automatic logic [29:0] cval(input logic [2:0] k);
        case (k)
            3'd0: cval = 30'd142002;
            3'd1: cval = 30'd135169;
            3'd2: cval = 30'd235715;
            3'd3: cval = 30'd117579;
            3'd4: cval = 30'd220519;
            3'd5: cval = 30'd41497;
            default: cval = 30'd0;
        endcase
    endfunction

    assign rom_data = cval(rom_addr);

    typedef struct {
        logic [29:0] x;
        logic [2:0]  k;
        logic [59:0] d;
        logic        last;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [29:0] x, input logic [2:0] k,
                       input logic [59:0] d);
        vec_t v;
        v.x = x;
        v.k = k;
        v.d = d;
        v.last = (k == 3'd5);
        vt.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint unsigned act,
                       input longint unsigned exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Wait for out_valid; cyc counts edges already consumed.
    task automatic wait_valid(inout int cyc);
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("wait_valid", out_valid, 1);
    endtask

    task automatic start(input logic [29:0] x);
        in_data = x;
        in_valid = 1'b1;
        chk("start_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!(out_valid && out_last) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_last", out_last, 1);
        tick();
        chk("drain_idle", in_ready, 1);
    endtask

    initial begin
        int cyc;
        int n;
        int acc;
        int prods;
        vec_t v;

        add(30'd1, 3'd0, 60'd142002);
        add(30'd1, 3'd1, 60'd135169);
        add(30'd1, 3'd2, 60'd235715);
        add(30'd1, 3'd3, 60'd117579);
        add(30'd1, 3'd4, 60'd220519);
        add(30'd1, 3'd5, 60'd41497);
        add(30'h3FFFFFFF, 3'd0, 60'd152473486349646);
        for (int k = 1; k < 6; k++)
            add(30'h3FFFFFFF, 3'(k), 60'(30'h3FFFFFFF) * 60'(cval(3'(k))));
        for (int k = 0; k < 6; k++)
            add(30'd12345, 3'(k), 60'd12345 * 60'(cval(3'(k))));

        // Reset state
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_addr", rom_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
`ifdef CRT_SCALE_SEQ_CNT_EN
        chk("rst_cnt", blk_cnt, 0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Table: one block per residue, out_ready held high
        foreach (vt[i]) begin
            v = vt[i];
            if (v.k == 3'd0) begin
                start(v.x);
            end else begin
                tick();
            end
            cyc = 1;
            wait_valid(cyc);
            chk("tbl_latency", cyc, 3);
            chk("tbl_data", out_data, v.d);
            chk("tbl_idx", out_idx, v.k);
            chk("tbl_last", out_last, v.last);
            if (v.last) begin
                tick();
                chk("tbl_idle_ready", in_ready, 1);
                chk("tbl_idle_valid", out_valid, 0);
            end
        end

        // Backpressure on idx 2
        out_ready = 1'b1;
        start(30'd3);
        n = 0;
        while (!(out_valid && out_idx == 3'd2) && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_idx", out_idx, 2);
            chk("hold_data", out_data, 60'd3 * 60'd235715);
        end
        out_ready = 1'b1;
        tick();
        cyc = 1;
        wait_valid(cyc);
        chk("resume_lat", cyc, 3);
        chk("resume_idx", out_idx, 3);
        chk("resume_data", out_data, 60'd3 * 60'd117579);
        drain();

        // Reset while holding idx 3
        start(30'd1);
        n = 0;
        while (!(out_valid && out_idx == 3'd3) && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("pre_rst_idx", out_idx, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_addr", rom_addr, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        start(30'd2);
        cyc = 1;
        wait_valid(cyc);
        chk("post_rst_lat", cyc, 3);
        chk("post_rst_data", out_data, 284004);
        chk("post_rst_idx", out_idx, 0);
        drain();

        // in_valid held across two back-to-back blocks
        acc = 0;
        prods = 0;
        in_data = 30'd5;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 38; i++) begin
            if (in_valid && in_ready)
                acc++;
            if (out_valid && out_ready) begin
                prods++;
                chk("b2b_data", out_data, 60'd5 * 60'(cval(out_idx)));
            end
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc, 2);
        chk("b2b_products", prods, 12);
        chk("b2b_idle", in_ready, 1);

`ifdef CRT_SCALE_SEQ_CNT_EN
        // Block counter across a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("cnt_zero", blk_cnt, 0);
        for (int b = 1; b <= 3; b++) begin
            start(30'(b));
            drain();
            chk("cnt_blk", blk_cnt, b);
        end
        start(30'd7);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("cnt_rst", blk_cnt, 0);
        tick();
        rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
